// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per cycle, LSB first, with a start/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // 1-bit slice: full adder from two half-adder stages
  logic ha0_s, ha0_c, ha1_c, bit_s, carry_nx;
  assign ha0_s    = a_sh_q[0] ^ b_sh_q[0];
  assign ha0_c    = a_sh_q[0] & b_sh_q[0];
  assign bit_s    = ha0_s ^ c_q;
  assign ha1_c    = ha0_s & c_q;
  assign carry_nx = ha0_c | ha1_c;

  // Partial sum word including the bit being produced this cycle
  logic [WIDTH-1:0] sum_shift_c;

  generate
    if (WIDTH > 1) begin : g_sh
      // Bits already produced; the newest enters at the MSB and moves toward the LSB
      logic [WIDTH-2:0] sum_sh_q, sum_sh_d;

      assign sum_shift_c = {bit_s, sum_sh_q};

      // Shift the sum register only while running; reload clears on accept
      always_comb begin
        sum_sh_d = sum_sh_q;
        if (state_q == S_IDLE && start) begin
          sum_sh_d = '0;
        end else if (state_q == S_RUN) begin
          sum_sh_d = sum_shift_c[WIDTH-1:1];
        end
      end

      // Sum shift register
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_sh_q <= '0;
        end else begin
          sum_sh_q <= sum_sh_d;
        end
      end
    end else begin : g_no_sh
      assign sum_shift_c = bit_s;
    end
  endgenerate

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = carry_nx;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          sum_d   = sum_shift_c;
          cout_d  = carry_nx;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8, sum8;
  logic [0:0] a1, b1, sum1;
  logic       busy8, done8, cout8;
  logic       busy1, done1, cout1;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(start1),
    .a    (a1),
    .b    (b1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=8 add; optionally pulse start with new operands mid-run
  task automatic add8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es, input logic ec, input bit inject);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();                                  // edge k: accepted
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (inject && i == 2) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end else if (inject && i == 3) begin
        start8 = 1'b0;
      end
      @(negedge clk);
      check($sformatf("busy8_c%0d", i), 32'(busy8), 32'd1);
      check($sformatf("nodone8_c%0d", i), 32'(done8), 32'd0);
      tick();
    end
    @(negedge clk);                          // cycle after edge k+8
    check("done8", 32'(done8), 32'd1);
    check("busy8_in_done", 32'(busy8), 32'd0);
    check($sformatf("sum8_%0h_%0h", av, bv), 32'(sum8), 32'(es));
    check($sformatf("cout8_%0h_%0h", av, bv), 32'(cout8), 32'(ec));
    tick();                                  // back to IDLE
  endtask

  task automatic add1(input logic av, input logic bv, input logic es, input logic ec);
    a1 = av; b1 = bv; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    @(negedge clk);
    check("busy1", 32'(busy1), 32'd1);
    check("nodone1", 32'(done1), 32'd0);
    tick();
    @(negedge clk);
    check("done1", 32'(done1), 32'd1);
    check("busy1_in_done", 32'(busy1), 32'd0);
    check($sformatf("sum1_%0d_%0d", av, bv), 32'(sum1), 32'(es));
    check($sformatf("cout1_%0d_%0d", av, bv), 32'(cout1), 32'(ec));
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;

    // Reset for two cycles
    tick();
    tick();
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("idle_busy", 32'(busy8), 32'd0);

    // Basic, overflow and alternating-bit adds
    add8(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
    add8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    add8(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0);

    // Start while busy is ignored; start in the cycle after done is accepted
    add8(8'h3C, 8'h0A, 8'h46, 1'b0, 1'b1);
    add8(8'h7F, 8'h81, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("quiet_done_%0d", i), 32'(done8), 32'd0);
      check($sformatf("quiet_busy_%0d", i), 32'(busy8), 32'd0);
      tick();
    end
    check("hold_sum", 32'(sum8), 32'h00);
    check("hold_cout", 32'(cout8), 32'd1);

    // Sum is held (not cleared) while the next add runs
    add8(8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // Mid-operation reset at edge k+4 of FF+FF
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();                                  // edge k
    start8 = 1'b0;
    tick();                                  // k+1
    tick();                                  // k+2
    tick();                                  // k+3
    @(negedge clk);
    check("mid_busy_pre", 32'(busy8), 32'd1);
    check("mid_sum_held", 32'(sum8), 32'h46);
    rst = 1'b1;
    tick();                                  // k+4: reset
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_sum", 32'(sum8), 32'd0);
    check("mid_rst_cout", 32'(cout8), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("mid_nodone_%0d", i), 32'(done8), 32'd0);
    end
    tick();
    add8(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);

    // WIDTH=1 half-adder truth table
    add1(1'b0, 1'b0, 1'b0, 1'b0);
    add1(1'b0, 1'b1, 1'b1, 1'b0);
    add1(1'b1, 1'b0, 1'b1, 1'b0);
    add1(1'b1, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
